// File: rtl/execute_pipe.sv
// Two-stage MIPS core: EX (operand read with WB bypass, ALU, branch resolve) and MW (data RAM, writeback).
// Owns the register file and data RAM and emits one-cycle fetch redirects for taken branches and jumps.
module execute_pipe #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int DMEM_WORDS = 256,
    parameter int MEM_LAT    = 1,
    localparam int RW        = $clog2(NREG),
    localparam int AW        = $clog2(DMEM_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_pc,
    input  logic [3:0]      in_aluctrl,
    input  logic [RW-1:0]   in_rs,
    input  logic [RW-1:0]   in_rt,
    input  logic [RW-1:0]   in_rd,
    input  logic [4:0]      in_shamt,
    input  logic [15:0]     in_imm,
    input  logic            in_ext_op,
    input  logic            in_alusrc,
    input  logic            in_reg_dst,
    input  logic            in_regwrite,
    input  logic            in_memtoreg,
    input  logic            in_memwrite,
    input  logic            in_branch,
    input  logic            in_bne,
    input  logic            in_jump,
    input  logic [25:0]     in_index,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic            busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rt_val;
        logic [RW-1:0]   dest;
        logic            regwrite;
        logic            memtoreg;
        logic            memwrite;
    } mw_t;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] dmem   [DMEM_WORDS];

    logic            mw_valid_q, mw_valid_d;
    mw_t             mw_q, mw_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;

    logic            commit, accept, taken;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] load_data, op_a, op_b, rt_val, ext_imm, alu_res;

    // MW commits in the cycle its wait counter reaches zero.
    assign commit    = mw_valid_q && (cnt_q == '0);
    assign mem_addr  = mw_q.result[AW-1:0];
    assign load_data = dmem[mem_addr];

    assign wb_valid  = rst_n && commit && mw_q.regwrite && (mw_q.dest != '0);
    assign wb_rd     = mw_q.dest;
    assign wb_data   = mw_q.memtoreg ? load_data : mw_q.result;

    assign in_ready  = rst_n && !redirect_valid_q && (!mw_valid_q || (cnt_q == '0));
    assign accept    = in_valid && in_ready;

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = mw_valid_q;

    // Operand read: register 0 is hard zero, a same-cycle writeback is forwarded.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        op_a   = '0;
        rt_val = '0;
        if (in_rs != '0) op_a = (wb_valid && wb_rd == in_rs) ? wb_data : regs_q[in_rs];
        if (in_rt != '0) rt_val = (wb_valid && wb_rd == in_rt) ? wb_data : regs_q[in_rt];
    end

    assign ext_imm = in_ext_op ? XLEN'($signed(in_imm)) : XLEN'(in_imm);
    assign op_b    = in_alusrc ? ext_imm : rt_val;
    assign taken   = in_branch && ((op_a == rt_val) ^ in_bne);

    always_comb begin
        alu_res = '0;
        case (in_aluctrl)
            4'd0:    alu_res = op_a & op_b;
            4'd1:    alu_res = op_a | op_b;
            4'd2:    alu_res = op_a + op_b;
            4'd3:    alu_res = op_a ^ op_b;
            4'd4:    alu_res = op_b << in_shamt;
            4'd5:    alu_res = op_b >> in_shamt;
            4'd6:    alu_res = op_a - op_b;
            4'd7:    alu_res[0] = $signed(op_a) < $signed(op_b);
            4'd12:   alu_res = ~(op_a | op_b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        mw_valid_d       = mw_valid_q;
        mw_d             = mw_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (commit) mw_valid_d = 1'b0;
        if (accept) begin
            mw_valid_d    = 1'b1;
            mw_d.result   = alu_res;
            mw_d.rt_val   = rt_val;
            mw_d.dest     = in_reg_dst ? in_rd : in_rt;
            mw_d.regwrite = in_regwrite;
            mw_d.memtoreg = in_memtoreg;
            mw_d.memwrite = in_memwrite;
            cnt_d         = (in_memtoreg || in_memwrite) ? CW'(MEM_LAT - 1) : '0;
            if (in_jump) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = {in_pc[31:28], in_index, 2'b00};
            end else if (taken) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = in_pc + 32'd4 + {{14{in_imm[15]}}, in_imm, 2'b00};
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            mw_valid_q       <= 1'b0;
            mw_q             <= '0;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mw_valid_q       <= mw_valid_d;
            mw_q             <= mw_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wb_valid) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // NOTE: data RAM has no reset so it maps onto RAM primitives; a store cut off by reset never lands.
    always_ff @(posedge clk) begin
        if (rst_n && commit && mw_q.memwrite) dmem[mem_addr] <= mw_q.rt_val;
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Randomised bench for execute_pipe against an in-order architectural model with cycle-timed expectations.
module tb_execute_pipe;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int DMEM_WORDS = 16;
    localparam int MEM_LAT    = 3;
    localparam int RW         = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid, in_ready;
    logic [31:0]     in_pc;
    logic [3:0]      in_aluctrl;
    logic [RW-1:0]   in_rs, in_rt, in_rd;
    logic [4:0]      in_shamt;
    logic [15:0]     in_imm;
    logic            in_ext_op, in_alusrc, in_reg_dst, in_regwrite, in_memtoreg, in_memwrite;
    logic            in_branch, in_bne, in_jump;
    logic [25:0]     in_index;
    logic            wb_valid;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            busy;

    execute_pipe #(.XLEN(XLEN), .NREG(NREG), .DMEM_WORDS(DMEM_WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_aluctrl(in_aluctrl),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_ext_op(in_ext_op), .in_alusrc(in_alusrc), .in_reg_dst(in_reg_dst),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_memwrite(in_memwrite),
        .in_branch(in_branch), .in_bne(in_bne), .in_jump(in_jump), .in_index(in_index),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   pc;
        logic [3:0]    ctrl;
        logic [RW-1:0] rs, rt, rd;
        logic [4:0]    shamt;
        logic [15:0]   imm;
        logic          ext_op, alusrc, reg_dst, regwrite, memtoreg, memwrite, branch, bne, jump;
        logic [25:0]   index;
    } instr_t;

    typedef struct {
        int            cyc;
        logic [RW-1:0] rd;
        logic [31:0]   data;
    } wb_exp_t;

    // Architectural state: each accepted instruction takes effect in program order.
    logic [31:0] m_regs [NREG];
    logic [31:0] m_mem  [DMEM_WORDS];
    wb_exp_t     wb_q[$];
    int          cyc = 0;
    int          ready_cyc, busy_until, redir_cyc;
    logic [31:0] redir_pc;
    bit          st_pend;
    int          st_cyc, st_addr;
    logic [31:0] st_old;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return b << sh;
            4'd5:    return b >> sh;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic instr_t mk_alu(input logic [3:0] op, input int rs, input int rt, input int rd, input int sh);
        instr_t i = '0;
        i.pc = 32'h100; i.ctrl = op; i.rs = RW'(rs); i.rt = RW'(rt); i.rd = RW'(rd); i.shamt = 5'(sh);
        i.reg_dst = 1'b1; i.regwrite = 1'b1;
        return i;
    endfunction

    function automatic instr_t mk_imm(input logic [3:0] op, input int rs, input int rt, input logic [15:0] imm,
                                      input logic ext);
        instr_t i = '0;
        i.pc = 32'h100; i.ctrl = op; i.rs = RW'(rs); i.rt = RW'(rt); i.imm = imm; i.ext_op = ext;
        i.alusrc = 1'b1; i.regwrite = 1'b1;
        return i;
    endfunction

    function automatic instr_t mk_mem(input bit is_load, input int rs, input int rt, input logic [15:0] imm);
        instr_t i = mk_imm(4'd2, rs, rt, imm, 1'b1);
        i.regwrite = is_load; i.memtoreg = is_load; i.memwrite = !is_load;
        return i;
    endfunction

    function automatic instr_t mk_br(input int rs, input int rt, input logic [15:0] imm, input logic bne,
                                     input logic [31:0] pc);
        instr_t i = '0;
        i.pc = pc; i.ctrl = 4'd6; i.rs = RW'(rs); i.rt = RW'(rt); i.imm = imm; i.branch = 1'b1; i.bne = bne;
        return i;
    endfunction

    task automatic model_accept(input instr_t ins);
        logic [31:0] a, rtv, b, ext, res, val, se;
        logic [RW-1:0] dest;
        int addr, lat;
        wb_exp_t e;
        a    = m_regs[ins.rs];
        rtv  = m_regs[ins.rt];
        ext  = ins.ext_op ? {{16{ins.imm[15]}}, ins.imm} : {16'h0, ins.imm};
        b    = ins.alusrc ? ext : rtv;
        res  = ref_alu(ins.ctrl, a, b, ins.shamt);
        addr = int'(res % DMEM_WORDS);
        lat  = (ins.memtoreg || ins.memwrite) ? MEM_LAT : 1;
        val  = ins.memtoreg ? m_mem[addr] : res;
        if (ins.memwrite) begin
            st_pend = 1'b1; st_cyc = cyc + MEM_LAT; st_addr = addr; st_old = m_mem[addr];
            m_mem[addr] = rtv;
        end
        dest = ins.reg_dst ? ins.rd : ins.rt;
        if (ins.regwrite && dest != '0) begin
            m_regs[dest] = val;
            e.cyc = cyc + lat; e.rd = dest; e.data = val;
            wb_q.push_back(e);
        end
        busy_until = cyc + lat;
        ready_cyc  = cyc + lat;
        se = {{16{ins.imm[15]}}, ins.imm};
        if (ins.jump) begin
            redir_cyc = cyc + 1; redir_pc = {ins.pc[31:28], ins.index, 2'b00}; ready_cyc = cyc + 2;
        end else if (ins.branch && ((a == rtv) ^ ins.bne)) begin
            redir_cyc = cyc + 1; redir_pc = ins.pc + 32'd4 + (se << 2); ready_cyc = cyc + 2;
        end
    endtask

    task automatic drive(input bit have, input instr_t ins);
        in_valid = have; in_pc = ins.pc; in_aluctrl = ins.ctrl; in_rs = ins.rs; in_rt = ins.rt; in_rd = ins.rd;
        in_shamt = ins.shamt; in_imm = ins.imm; in_ext_op = ins.ext_op; in_alusrc = ins.alusrc;
        in_reg_dst = ins.reg_dst; in_regwrite = ins.regwrite; in_memtoreg = ins.memtoreg;
        in_memwrite = ins.memwrite; in_branch = ins.branch; in_bne = ins.bne; in_jump = ins.jump;
        in_index = ins.index;
    endtask

    // One clock cycle, entered and left at a falling edge where outputs are stable.
    task automatic step(input bit have, input instr_t ins, output bit acc);
        drive(have, ins);
        check("in_ready", in_ready, cyc >= ready_cyc);
        check("busy", busy, cyc <= busy_until);
        if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
            check("wb_valid", wb_valid, 1);
            check("wb_rd", wb_rd, wb_q[0].rd);
            check("wb_data", wb_data, wb_q[0].data);
            void'(wb_q.pop_front());
        end else begin
            check("wb_valid_idle", wb_valid, 0);
        end
        if (redir_cyc == cyc) begin
            check("redirect_valid", redirect_valid, 1);
            check("redirect_pc", redirect_pc, redir_pc);
        end else begin
            check("redirect_idle", redirect_valid, 0);
        end
        acc = have && in_ready;
        if (acc) model_accept(ins);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input instr_t ins);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, ins, acc);
        if (!acc) check("issue_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, instr_t'('0), acc);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 20 && (wb_q.size() > 0 || cyc <= busy_until); k++) step(1'b0, instr_t'('0), acc);
        check("drain_empty", wb_q.size(), 0);
    endtask

    task automatic do_reset();
        drive(1'b0, instr_t'('0));
        rst_n = 1'b0;
        if (st_pend && st_cyc >= cyc) m_mem[st_addr] = st_old;
        st_pend = 1'b0;
        #1 check("ready_in_reset", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        wb_q.delete();
        ready_cyc = cyc; busy_until = -1; redir_cyc = -1;
        #1 check("ready_after_reset", in_ready, 1);
        check("busy_after_reset", busy, 0);
    endtask

    function automatic instr_t rand_instr();
        logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd9};
        instr_t i;
        int rs = $urandom_range(0, NREG - 1);
        int rt = $urandom_range(0, NREG - 1);
        case ($urandom_range(0, 5))
            0: i = mk_alu(ops[$urandom_range(0, 9)], rs, rt, $urandom_range(0, NREG - 1), $urandom_range(0, 31));
            1: i = mk_imm(ops[$urandom_range(0, 3)], rs, rt, 16'($urandom), 1'($urandom));
            2: i = mk_mem(1'b1, rs, rt, 16'($urandom_range(0, 40)));
            3: i = mk_mem(1'b0, rs, rt, 16'($urandom_range(0, 40)));
            4: i = mk_br(rs, ($urandom_range(0, 1) == 0) ? rs : rt, 16'($urandom), 1'($urandom),
                         $urandom & 32'hFFFF_FFFC);
            default: begin
                i = '0; i.jump = 1'b1; i.index = 26'($urandom); i.pc = $urandom & 32'hFFFF_FFFC;
            end
        endcase
        return i;
    endfunction

    initial begin
        instr_t j;
        st_pend = 1'b0; ready_cyc = 0; busy_until = -1; redir_cyc = -1;
        for (int i = 0; i < DMEM_WORDS; i++) m_mem[i] = '0;
        @(negedge clk);
        do_reset();

        // Known RAM contents so every later load has a defined expectation.
        for (int i = 0; i < DMEM_WORDS; i++) begin
            issue(mk_imm(4'd2, 0, 10, 16'(i * 37 + 11), 1'b1));
            issue(mk_mem(1'b0, 0, 10, 16'(i)));
        end

        // Back-to-back dependent ALU ops through the bypass.
        issue(mk_imm(4'd2, 0, 1, 16'd5, 1'b1));
        issue(mk_imm(4'd2, 0, 2, 16'd3, 1'b1));
        issue(mk_alu(4'd2, 1, 2, 3, 0));
        // Store then load to the same address under multi-cycle memory.
        issue(mk_mem(1'b0, 0, 3, 16'd4));
        issue(mk_mem(1'b1, 0, 4, 16'd4));
        // Backward taken branch and a jump.
        issue(mk_br(1, 1, 16'hFFFE, 1'b0, 32'h20));
        issue(mk_br(1, 2, 16'h0003, 1'b0, 32'h40));
        j = '0; j.jump = 1'b1; j.index = 26'h2AB_CDEF; j.pc = 32'hA000_0010;
        issue(j);
        // Writes to r0 are dropped and r0 still reads zero.
        issue(mk_alu(4'd2, 1, 2, 0, 0));
        issue(mk_alu(4'd2, 0, 1, 5, 0));
        // Signed compare, wrap-around subtract, RAM address truncation.
        issue(mk_imm(4'd2, 0, 1, 16'd1, 1'b1));
        issue(mk_imm(4'd2, 0, 6, 16'hFFFF, 1'b1));
        issue(mk_alu(4'd7, 6, 1, 7, 0));
        issue(mk_alu(4'd6, 0, 1, 8, 0));
        issue(mk_mem(1'b0, 0, 6, 16'(DMEM_WORDS + 5)));
        issue(mk_mem(1'b1, 0, 11, 16'd5));
        drain();
        // Reset while a store waits in MW: the store must not land.
        issue(mk_mem(1'b0, 0, 5, 16'd9));
        idle(1);
        do_reset();
        issue(mk_mem(1'b1, 0, 9, 16'd9));
        drain();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(rand_instr());
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
